// File: rtl/dot4_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dot4_mac_pkg
//  Purpose  : Shared types and widths for the dot4 multiply-accumulate block.
//  Revision : 1.0  initial release
// ============================================================================
package dot4_mac_pkg;

    // Operand, product and pair-count widths
    localparam int OPW   = 4;
    localparam int PRODW = 8;
    localparam int CNTW  = 8;

    // Group-control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : dot4_mac_pkg
`default_nettype wire

// File: rtl/mac_mul4x4.sv
`default_nettype none
// ============================================================================
//  Module   : mac_mul4x4
//  Purpose  : Combinational 4x4 -> 8-bit unsigned array multiplier.
//  Revision : 1.0  initial release
// ============================================================================
module mac_mul4x4
    import dot4_mac_pkg::*;
(
    input  logic [OPW-1:0]   i_a,
    input  logic [OPW-1:0]   i_b,
    output logic [PRODW-1:0] o_p
);

    // One shifted partial product per bit of B, each already at full product
    // width so the final sum keeps bit 7 (15*15 = 225).
    logic [PRODW-1:0] w_pp [OPW];

    generate
        for (genvar gi = 0; gi < OPW; gi++) begin : g_pp
            assign w_pp[gi] = i_b[gi] ? (PRODW'(i_a) << gi) : '0;
        end
    endgenerate

    // Sum of the four rows; the true product never exceeds 8 bits.
    assign o_p = w_pp[0] + w_pp[1] + w_pp[2] + w_pp[3];

endmodule : mac_mul4x4
`default_nettype wire

// File: rtl/dot4_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : dot4_mac_accumulator
//  Purpose  : Two-stage multiply-accumulate of up to N_TERMS 4-bit operand
//             pairs per group, with valid/ready on input and output.
//  Revision : 1.0  initial release
// ============================================================================
module dot4_mac_accumulator
    import dot4_mac_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_a,
    input  logic [OPW-1:0]   in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNTW-1:0]  out_count,
    output logic             busy
);

    localparam logic [CNTW-1:0] c_last_idx = CNTW'(N_TERMS - 1);

    // Stage 1 registers
    logic           ready_en_q, ready_en_d;
    logic           v1_q, v1_d;
    logic [OPW-1:0] a1_q, a1_d;
    logic [OPW-1:0] b1_q, b1_d;
    logic           last1_q, last1_d;

    // Stage 2 registers
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNTW-1:0]  count_q, count_d;

    logic [PRODW-1:0] w_prod;
    logic [ACC_W-1:0] w_sum_next;
    logic             w_complete1;
    logic             w_accept;

    mac_mul4x4 u_mul (
        .i_a (a1_q),
        .i_b (b1_q),
        .o_p (w_prod)
    );

    // The S1 pair closes the group if flagged last or it is the N_TERMS-th pair
    assign w_complete1 = v1_q && (last1_q || (cnt_q == c_last_idx));
    assign w_sum_next  = acc_q + ACC_W'(w_prod);

    // Input is blocked while a result is pending or about to be produced;
    // ready_en_q keeps it low in the cycle right after reset.
    assign out_valid = (state_q == DONE);
    assign in_ready  = ready_en_q && !out_valid && !w_complete1;
    assign w_accept  = in_valid && in_ready;
    assign busy      = (state_q != IDLE) || v1_q;
    assign out_sum   = sum_q;
    assign out_count = count_q;

    // Stage 1 capture of an accepted pair
    always_comb begin
        ready_en_d = 1'b1;
        v1_d       = w_accept;
        a1_d       = a1_q;
        b1_d       = b1_q;
        last1_d    = last1_q;
        if (w_accept) begin
            a1_d    = in_a;
            b1_d    = in_b;
            last1_d = in_last;
        end
    end

    // Stage 2 accumulate, result capture and group-control next state
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        count_d = count_q;

        if (v1_q) begin
            if (w_complete1) begin
                sum_d   = w_sum_next;
                count_d = cnt_q + CNTW'(1);
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = w_sum_next;
                cnt_d = cnt_q + CNTW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (v1_q) begin
                    state_d = w_complete1 ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_complete1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Group-control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers for both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            v1_q       <= 1'b0;
            a1_q       <= '0;
            b1_q       <= '0;
            last1_q    <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            count_q    <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            v1_q       <= v1_d;
            a1_q       <= a1_d;
            b1_q       <= b1_d;
            last1_q    <= last1_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            count_q    <= count_d;
        end
    end

endmodule : dot4_mac_accumulator
`default_nettype wire

// File: tb/tb_dot4_mac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dot4_mac_accumulator
//  Purpose  : Self-checking bench for dot4_mac_accumulator (N_TERMS=4 and 1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dot4_mac_accumulator;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       last;
        int         exp_sum;
        int         exp_cnt;   // 0: this pair does not close a group
    } vec_t;

    typedef struct {
        int sum;
        int cnt;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, busy;
    logic [3:0]  in_a, in_b;
    logic [11:0] out_sum;
    logic [7:0]  out_count;

    logic        u1_in_valid, u1_in_ready, u1_in_last, u1_out_valid, u1_out_ready, u1_busy;
    logic [3:0]  u1_in_a, u1_in_b;
    logic [7:0]  u1_out_sum;
    logic [7:0]  u1_out_count;

    int   nchk = 0;
    int   nerr = 0;
    bit   rand_rdy = 1'b0;
    vec_t tbl[$];
    res_t expq[$];
    int   md_sum = 0;
    int   md_cnt = 0;

    always #5 clk = ~clk;

    dot4_mac_accumulator #(.N_TERMS(4), .ACC_W(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
        .busy(busy)
    );

    dot4_mac_accumulator #(.N_TERMS(1), .ACC_W(8)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(u1_in_valid), .in_ready(u1_in_ready), .in_a(u1_in_a), .in_b(u1_in_b),
        .in_last(u1_in_last),
        .out_valid(u1_out_valid), .out_ready(u1_out_ready), .out_sum(u1_out_sum),
        .out_count(u1_out_count), .busy(u1_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge; optionally randomise back-pressure
    task automatic tick();
        @(negedge clk);
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Offer one pair and return on the falling edge after it was accepted
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("accept_timeout", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        u1_in_valid = 1'b1;
        u1_in_a     = a;
        u1_in_b     = b;
        u1_in_last  = 1'b0;
        while (!u1_in_ready && n < 200) begin
            tick();
            n++;
        end
        chk("n1_accept_timeout", int'(u1_in_ready), 1);
        tick();
        u1_in_valid = 1'b0;
    endtask

    // Reference: groups close on last or on the N-th pair; sum of products
    task automatic model_pair(input int a, input int b, input bit last);
        res_t r;
        md_sum += a * b;
        md_cnt++;
        if (last || md_cnt == 4) begin
            r.sum = md_sum % 4096;
            r.cnt = md_cnt;
            expq.push_back(r);
            md_sum = 0;
            md_cnt = 0;
        end
    endtask

    task automatic push_exp(input int s, input int c);
        res_t r;
        r.sum = s;
        r.cnt = c;
        expq.push_back(r);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_pending", expq.size(), 0);
    endtask

    task automatic add_vec(input logic [3:0] a, input logic [3:0] b, input logic l,
                           input int s, input int c);
        vec_t v;
        v.a = a; v.b = b; v.last = l; v.exp_sum = s; v.exp_cnt = c;
        tbl.push_back(v);
    endtask

    // Result scoreboard: every output handshake is matched against the queue
    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_result: got sum=%0d count=%0d, required no result",
                         out_sum, out_count);
            end else begin
                res_t e;
                e = expq.pop_front();
                chk("res_sum", int'(out_sum), e.sum);
                chk("res_count", int'(out_count), e.cnt);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec(4'd3,  4'd4,  1'b0, 0,   0);
        add_vec(4'd5,  4'd6,  1'b0, 0,   0);
        add_vec(4'd7,  4'd8,  1'b0, 0,   0);
        add_vec(4'd1,  4'd2,  1'b0, 100, 4);
        add_vec(4'd15, 4'd15, 1'b0, 0,   0);
        add_vec(4'd15, 4'd15, 1'b0, 0,   0);
        add_vec(4'd15, 4'd15, 1'b0, 0,   0);
        add_vec(4'd15, 4'd15, 1'b0, 900, 4);
        add_vec(4'd2,  4'd3,  1'b0, 0,   0);
        add_vec(4'd4,  4'd4,  1'b1, 22,  2);
        add_vec(4'd5,  4'd5,  1'b1, 25,  1);
        add_vec(4'd1,  4'd1,  1'b0, 0,   0);
        add_vec(4'd2,  4'd2,  1'b0, 0,   0);
        add_vec(4'd3,  4'd3,  1'b0, 0,   0);
        add_vec(4'd4,  4'd4,  1'b1, 30,  4);

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        u1_in_valid = 1'b0; u1_in_a = '0; u1_in_b = '0; u1_in_last = 1'b0; u1_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", int'(in_ready), 1);

        // Directed table, with latency and one-cycle valid on each closing pair
        foreach (tbl[i]) begin
            send(tbl[i].a, tbl[i].b, tbl[i].last);
            if (tbl[i].exp_cnt != 0) begin
                push_exp(tbl[i].exp_sum, tbl[i].exp_cnt);
                chk("lat_valid_early", int'(out_valid), 0);
                chk("bubble_in_ready", int'(in_ready), 0);
                tick();
                chk("lat_valid", int'(out_valid), 1);
                tick();
                chk("valid_one_cycle", int'(out_valid), 0);
            end
        end
        drain();

        // Back-pressure hold with input held and wiggling
        out_ready = 1'b0;
        send(4'd6, 4'd7, 1'b0);
        send(4'd1, 4'd1, 1'b0);
        send(4'd0, 4'd9, 1'b0);
        send(4'd3, 4'd5, 1'b0);
        push_exp(58, 4);
        tick();
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_a = 4'($urandom_range(0, 15));
            in_b = 4'($urandom_range(0, 15));
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_sum", int'(out_sum), 58);
            chk("hold_count", int'(out_count), 4);
            chk("hold_in_ready", int'(in_ready), 0);
            tick();
        end
        in_a = 4'd9;
        in_b = 4'd9;
        out_ready = 1'b1;
        chk("hs_in_ready", int'(in_ready), 0);
        push_exp(81, 1);
        tick();
        chk("after_hs_in_ready", int'(in_ready), 1);
        chk("after_hs_valid", int'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();

        // Reset while a result is held: it must be discarded
        out_ready = 1'b0;
        send(4'd7, 4'd7, 1'b1);
        tick();
        chk("pre_rst_valid", int'(out_valid), 1);
        rst = 1'b1;
        tick();
        chk("rst_hold_valid", int'(out_valid), 0);
        chk("rst_hold_sum", int'(out_sum), 0);
        chk("rst_hold_count", int'(out_count), 0);
        chk("rst_hold_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Reset mid-group, then a fresh group from zero
        send(4'd5, 4'd5, 1'b0);
        send(4'd6, 4'd6, 1'b0);
        rst = 1'b1;
        tick();
        chk("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) send(4'd1, 4'd1, 1'b0);
        push_exp(4, 4);
        drain();

        // Randomised traffic against the reference model
        rand_rdy = 1'b1;
        md_sum = 0;
        md_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            int  ra, rb;
            bit  rl;
            repeat ($urandom_range(0, 1)) tick();
            ra = $urandom_range(0, 15);
            rb = $urandom_range(0, 15);
            rl = ($urandom_range(0, 5) == 0) || (i == 79);
            send(4'(ra), 4'(rb), rl);
            model_pair(ra, rb, rl);
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        // Single-term build: every pair is its own group
        send1(4'd9, 4'd9);
        chk("n1_valid_early", int'(u1_out_valid), 0);
        tick();
        chk("n1_valid_a", int'(u1_out_valid), 1);
        chk("n1_sum_a", int'(u1_out_sum), 81);
        chk("n1_count_a", int'(u1_out_count), 1);
        tick();
        chk("n1_valid_clear", int'(u1_out_valid), 0);
        send1(4'd0, 4'd7);
        tick();
        chk("n1_valid_b", int'(u1_out_valid), 1);
        chk("n1_sum_b", int'(u1_out_sum), 0);
        chk("n1_count_b", int'(u1_out_count), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule : tb_dot4_mac_accumulator
`default_nettype wire
